adrv9009_tx_tone_src: RTL and testbench

//  Synthesizable transmit-side test source for the ADRV9009 path: produces a scheduled 16-bit stepped-tone

---
 rtl/adrv9009_tx_pkg.sv | 27 ++
 rtl/adrv9009_tx_step_tone.sv | 53 +++++
 rtl/adrv9009_tx_tone_src.sv | 123 ++++++++++++
 tb/tb_adrv9009_tx_tone_src.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/adrv9009_tx_pkg.sv
// Shared types and level tables for the ADRV9009 transmit tone source.
package adrv9009_tx_pkg;

  typedef logic signed [15:0] sample_t;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LEAD   = 3'd1,
    TONE_A = 3'd2,
    TONE_B = 3'd3,
    TONE_C = 3'd4,
    SUM    = 3'd5
  } seg_e;

  localparam sample_t SAMPLE_MAX = 16'sh7fff;
  localparam sample_t SAMPLE_MIN = 16'sh8000;

  localparam sample_t T8 [8] = '{
    sample_t'(0),      sample_t'(23170),  sample_t'(32767),  sample_t'(23170),
    sample_t'(0),      sample_t'(-23170), sample_t'(-32768), sample_t'(-23170)
  };

  localparam sample_t T4 [4] = '{
    sample_t'(0), sample_t'(32767), sample_t'(0), sample_t'(-32768)
  };

endpackage

// File: rtl/adrv9009_tx_step_tone.sv
// Stepped-tone phase generator: holds each table level PERIOD+1 samples, PHASES (8 or 4) levels.
// level always reflects the sample *after* the one currently on the output register.
module adrv9009_tx_step_tone
  import adrv9009_tx_pkg::*;
#(
  parameter int PERIOD = 0,
  parameter int PHASES = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               clr,
  input  logic               adv,
  output logic signed [15:0] level
);

  localparam int HW = (PERIOD > 0) ? $clog2(PERIOD + 1) : 1;
  localparam logic [HW-1:0] HOLD_MAX  = HW'(PERIOD);
  // clr loads the position of sample index 1, since sample 0 is emitted by the start itself
  localparam logic [HW-1:0] CLR_HOLD  = (PERIOD > 0) ? HW'(1) : HW'(0);
  localparam logic [2:0]    CLR_PHASE = (PERIOD > 0) ? 3'd0 : 3'd1;
  localparam logic [2:0]    PH_LAST   = 3'(PHASES - 1);

  generate
    if (PHASES != 8 && PHASES != 4) begin : g_bad_phases
      $error("adrv9009_tx_step_tone: PHASES must be 8 or 4");
    end
  endgenerate

  logic [HW-1:0] hold;
  logic [2:0]    phase;

  always_ff @(posedge clk) begin
    if (reset) begin
      hold  <= '0;
      phase <= '0;
    end else if (clr) begin
      hold  <= CLR_HOLD;
      phase <= CLR_PHASE;
    end else if (adv) begin
      if (hold == HOLD_MAX) begin
        hold  <= '0;
        phase <= (phase == PH_LAST) ? 3'd0 : phase + 3'd1;
      end else begin
        hold <= hold + HW'(1);
      end
    end
  end

  always_comb begin
    level = (PHASES == 4) ? T4[phase[1:0]] : T8[phase];
  end

endmodule

// File: rtl/adrv9009_tx_tone_src.sv
// Scheduled stepped-tone test source (LEAD, A, B, C, A+C) with a registered valid/ready output.
// Define TX_TONE_SAT_EN to saturate the A+C sum instead of wrapping it.
module adrv9009_tx_tone_src
  import adrv9009_tx_pkg::*;
#(
  parameter int PERIOD_A = 24,
  parameter int PERIOD_B = 9,
  parameter int PERIOD_C = 0,
  parameter int LEAD_LEN = 15,
  parameter int LEN_A    = 975,
  parameter int LEN_B    = 510,
  parameter int LEN_C    = 500
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               stop,
  input  logic               out_ready,
  output logic               out_valid,
  output logic signed [15:0] out,
  output logic [2:0]         seg,
  output logic               busy
);

  generate
    if (LEAD_LEN < 1 || LEN_A < 1 || LEN_B < 1 || LEN_C < 1) begin : g_bad_len
      $error("adrv9009_tx_tone_src: segment lengths must be >= 1");
    end
  endgenerate

  localparam logic [15:0] LEAD_LAST = 16'(LEAD_LEN - 1);
  localparam logic [15:0] A_LAST    = 16'(LEN_A - 1);
  localparam logic [15:0] B_LAST    = 16'(LEN_B - 1);
  localparam logic [15:0] C_LAST    = 16'(LEN_C - 1);

  // Handshake: a sample transfers on every clk edge where out_valid && out_ready;
  // out_valid never depends on out_ready and out/seg hold until that transfer.
  seg_e        state, state_d, seg_nxt;
  logic [15:0] cnt, cnt_d;
  sample_t     out_d, lvl_a, lvl_b, lvl_c, sum_v;
  logic signed [16:0] sum17;
  logic        beat, clr, adv, last;

  adrv9009_tx_step_tone #(.PERIOD(PERIOD_A), .PHASES(8)) u_tone_a (
    .clk(clk), .reset(reset), .clr(clr), .adv(adv), .level(lvl_a));
  adrv9009_tx_step_tone #(.PERIOD(PERIOD_B), .PHASES(8)) u_tone_b (
    .clk(clk), .reset(reset), .clr(clr), .adv(adv), .level(lvl_b));
  adrv9009_tx_step_tone #(.PERIOD(PERIOD_C), .PHASES(4)) u_tone_c (
    .clk(clk), .reset(reset), .clr(clr), .adv(adv), .level(lvl_c));

  assign out_valid = (state != IDLE);
  assign busy      = (state != IDLE);
  assign seg       = state;
  assign beat      = out_valid & out_ready;

  always_comb begin
    sum17 = {lvl_a[15], lvl_a} + {lvl_c[15], lvl_c};
`ifdef TX_TONE_SAT_EN
    if (sum17[16] != sum17[15]) sum_v = sum17[16] ? SAMPLE_MIN : SAMPLE_MAX;
    else                        sum_v = sum17[15:0];
`else
    sum_v = sum17[15:0];
`endif
  end

  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    out_d   = out;
    clr     = 1'b0;
    adv     = 1'b0;
    last    = 1'b0;
    seg_nxt = state;
    if (stop) begin
      state_d = IDLE;
      cnt_d   = '0;
      out_d   = '0;
    end else if (state == IDLE) begin
      if (start) begin
        state_d = LEAD;
        cnt_d   = '0;
        out_d   = '0;
        clr     = 1'b1;
      end
    end else if (beat) begin
      adv = 1'b1;
      case (state)
        LEAD:    begin last = (cnt == LEAD_LAST); seg_nxt = TONE_A; end
        TONE_A:  begin last = (cnt == A_LAST);    seg_nxt = TONE_B; end
        TONE_B:  begin last = (cnt == B_LAST);    seg_nxt = TONE_C; end
        TONE_C:  begin last = (cnt == C_LAST);    seg_nxt = SUM;    end
        default: begin last = 1'b0;               seg_nxt = state;  end
      endcase
      if (last) begin
        state_d = seg_nxt;
        cnt_d   = '0;
      end else if (state != SUM) begin
        cnt_d = cnt + 16'd1;
      end
      // out is loaded with the next sample, so select by the segment it belongs to
      case (state_d)
        TONE_A:  out_d = lvl_a;
        TONE_B:  out_d = lvl_b;
        TONE_C:  out_d = lvl_c;
        SUM:     out_d = sum_v;
        default: out_d = '0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
      out   <= '0;
    end else begin
      state <= state_d;
      cnt   <= cnt_d;
      out   <= out_d;
    end
  end

endmodule

// File: tb/tb_adrv9009_tx_tone_src.sv
// Directed bench for adrv9009_tx_tone_src: vector table against captured stream plus stall/stop/reset sequences.
module tb_adrv9009_tx_tone_src;
  import adrv9009_tx_pkg::*;

  logic               clk = 1'b0;
  logic               reset, start, stop, out_ready;
  logic               out_valid, busy;
  logic signed [15:0] out;
  logic [2:0]         seg;

  int total = 0;
  int bad   = 0;

  typedef struct {
    int          k;
    logic [15:0] exp_out;
    logic [2:0]  exp_seg;
  } vec_t;

  vec_t        vecs[$];
  logic [15:0] exp_q[$];
  logic [15:0] got_out [3][2200];
  logic [2:0]  got_seg [3][2200];

  adrv9009_tx_tone_src dut (
    .clk(clk), .reset(reset), .start(start), .stop(stop), .out_ready(out_ready),
    .out_valid(out_valid), .out(out), .seg(seg), .busy(busy));

  // clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: sim time expired, required $finish before 1000000");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_valid"}, 32'(out_valid), 32'd0);
    check({tag, "_out"},   32'(out),       32'd0);
    check({tag, "_seg"},   32'(seg),       32'd0);
    check({tag, "_busy"},  32'(busy),      32'd0);
  endtask

  // called at a negedge; returns at the negedge where sample 0 is presented
  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // records n accepted samples into run r; optional stall of stall_len cycles at sample stall_at
  task automatic capture(input int r, input int n, input int stall_at, input int stall_len);
    int          idx = 0;
    int          guard = 0;
    bit          stalled = 1'b0;
    logic [15:0] frz_o;
    logic [2:0]  frz_s;
    while (idx < n && guard < n + 100) begin
      if (!stalled && idx == stall_at) begin
        stalled   = 1'b1;
        frz_o     = out;
        frz_s     = seg;
        out_ready = 1'b0;
        for (int i = 0; i < stall_len; i++) begin
          @(negedge clk);
          guard++;
          check("stall_out_frozen", 32'(out), 32'(frz_o));
          check("stall_seg_frozen", 32'(seg), 32'(frz_s));
        end
        out_ready = 1'b1;
      end
      if (out_valid && out_ready) begin
        got_out[r][idx] = out;
        got_seg[r][idx] = seg;
        idx++;
      end
      if (idx < n) begin
        @(negedge clk);
        guard++;
      end
    end
    check("capture_count", 32'(idx), 32'(n));
  endtask

  initial begin
    int errs;
    reset = 1'b1; start = 1'b0; stop = 1'b0; out_ready = 1'b1;

    vecs.push_back('{0,    16'(0),      3'd1});
    vecs.push_back('{14,   16'(0),      3'd1});
    vecs.push_back('{15,   16'(0),      3'd2});
    vecs.push_back('{24,   16'(0),      3'd2});
    vecs.push_back('{25,   16'(23170),  3'd2});
    vecs.push_back('{49,   16'(23170),  3'd2});
    vecs.push_back('{50,   16'(32767),  3'd2});
    vecs.push_back('{74,   16'(32767),  3'd2});
    vecs.push_back('{75,   16'(23170),  3'd2});
    vecs.push_back('{989,  16'(-23170), 3'd2});
    vecs.push_back('{990,  16'(23170),  3'd3});
    vecs.push_back('{1000, 16'(0),      3'd3});
    vecs.push_back('{1010, 16'(-23170), 3'd3});
    vecs.push_back('{1499, 16'(-23170), 3'd3});
    vecs.push_back('{1500, 16'(0),      3'd4});
    vecs.push_back('{1999, 16'(-32768), 3'd4});
    vecs.push_back('{2000, 16'(0),      3'd5});
    vecs.push_back('{2001, 16'(32767),  3'd5});
`ifdef TX_TONE_SAT_EN
    vecs.push_back('{2053, 16'(32767),  3'd5});
    vecs.push_back('{2151, 16'(-32768), 3'd5});
`else
    vecs.push_back('{2053, 16'(-2),     3'd5});
    vecs.push_back('{2151, 16'(0),      3'd5});
`endif

    // reset state, then idle with no start
    repeat (3) @(negedge clk);
    check_idle("reset");
    reset = 1'b0;
    @(negedge clk);
    check_idle("idle_no_start");

    // full schedule, ready held high
    pulse_start();
    capture(0, 2200, -1, 0);
    foreach (vecs[i]) begin
      check($sformatf("out_k%0d", vecs[i].k), 32'(got_out[0][vecs[i].k]), 32'(vecs[i].exp_out));
      check($sformatf("seg_k%0d", vecs[i].k), 32'(got_seg[0][vecs[i].k]), 32'(vecs[i].exp_seg));
    end

    // TONE_C repeats the 4-level table by k mod 4
    for (int k = 1500; k < 2000; k++) begin
      case (k % 4)
        0: exp_q.push_back(16'(0));
        1: exp_q.push_back(16'(32767));
        2: exp_q.push_back(16'(0));
        default: exp_q.push_back(16'(-32768));
      endcase
    end
    errs = 0;
    for (int k = 1500; k < 2000; k++) begin
      logic [15:0] e;
      e = exp_q.pop_front();
      if (got_out[0][k] !== e || got_seg[0][k] !== 3'd4) errs++;
    end
    check("tone_c_run_errors", 32'(errs), 32'd0);

    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    check_idle("stop_in_sum");

    // stall at k=100, then stop at k=1200 in TONE_B
    @(negedge clk);
    pulse_start();
    capture(1, 1200, 100, 7);
    errs = 0;
    for (int k = 0; k < 1200; k++)
      if (got_out[1][k] !== got_out[0][k] || got_seg[1][k] !== got_seg[0][k]) errs++;
    check("stall_stream_errors", 32'(errs), 32'd0);
    @(negedge clk);
    check("k1200_seg",  32'(seg),  32'd3);
    check("k1200_busy", 32'(busy), 32'd1);
    check("k1200_out",  32'(out),  32'(got_out[0][1200]));
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    check_idle("stop_in_b");

    // restart from k=0
    pulse_start();
    check("restart_valid", 32'(out_valid), 32'd1);
    check("restart_out",   32'(out),       32'd0);
    check("restart_seg",   32'(seg),       32'd1);

    // reset during SUM with start held high
    capture(2, 2010, -1, 0);
    @(negedge clk);
    check("pre_reset_seg", 32'(seg), 32'd5);
    reset = 1'b1;
    start = 1'b1;
    @(negedge clk);
    check_idle("reset_in_sum");
    reset = 1'b0;
    start = 1'b0;
    @(negedge clk);
    check_idle("after_reset");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
